// File: rtl/led_scan_ctrl_if.sv
// Panel-side and pixel-source signals of the LED scan controller.
// The controller sits on the slave modport; whoever drives init/px_ready uses master.
interface led_scan_ctrl_if #(
  parameter int COLS   = 64,
  parameter int ROWS   = 32,
  parameter int PLANES = 4
);
  localparam int CW = (COLS   > 1) ? $clog2(COLS)   : 1;
  localparam int RW = (ROWS   > 1) ? $clog2(ROWS)   : 1;
  localparam int PW = (PLANES > 1) ? $clog2(PLANES) : 1;

  logic          init;
  logic          px_ready;
  logic [RW-1:0] row;
  logic [CW-1:0] col;
  logic [PW-1:0] plane;
  logic [RW-1:0] disp_row;
  logic          px_load;
  logic          px_clk_en;
  logic          latch;
  logic          noe;
  logic          busy;
  logic          frame_done;

  modport slave (
    input  init, px_ready,
    output row, col, plane, disp_row, px_load, px_clk_en, latch, noe, busy, frame_done
  );

  modport master (
    output init, px_ready,
    input  row, col, plane, disp_row, px_load, px_clk_en, latch, noe, busy, frame_done
  );
endinterface

// File: rtl/led_scan_ctrl.sv
// Binary-code-modulation scan controller for a row-multiplexed LED panel:
// shifts one row/plane of pixels, latches it, then shows it for BASE_DLY<<plane cycles.
//
// state | meaning
// IDLE  | stopped, panel blanked, waiting for init
// FETCH | waiting for px_ready on current col/row/plane; px_load when it arrives
// SHIFT | one panel shift-clock pulse, then next column or latch
// LATCH | latch shifted row into panel, load display row and delay counter
// SHOW  | panel enabled for BASE_DLY<<plane cycles, then advance plane/row
module led_scan_ctrl #(
  parameter int COLS     = 64,
  parameter int ROWS     = 32,
  parameter int PLANES   = 4,
  parameter int BASE_DLY = 16
) (
  input  logic           clk,
  input  logic           rst,
  led_scan_ctrl_if.slave bus
);
  localparam int CW      = (COLS   > 1) ? $clog2(COLS)   : 1;
  localparam int RW      = (ROWS   > 1) ? $clog2(ROWS)   : 1;
  localparam int PW      = (PLANES > 1) ? $clog2(PLANES) : 1;
  localparam int DLY_MAX = BASE_DLY << (PLANES - 1);
  localparam int DW      = $clog2(DLY_MAX + 1);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] FETCH = 3'd1;
  localparam logic [2:0] SHIFT = 3'd2;
  localparam logic [2:0] LATCH = 3'd3;
  localparam logic [2:0] SHOW  = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [PW-1:0] plane_q, plane_d;
  logic [RW-1:0] disp_row_q, disp_row_d;
  logic [DW-1:0] dly_q, dly_d;

  logic last_show;
  logic last_plane;
  logic last_row;

  // Terminal count at 1 so SHOW spans exactly the loaded number of cycles.
  assign last_show  = (state_q == SHOW) && (dly_q <= DW'(1));
  assign last_plane = (plane_q == PW'(PLANES - 1));
  assign last_row   = (row_q == RW'(ROWS - 1));

  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    row_d      = row_q;
    plane_d    = plane_q;
    disp_row_d = disp_row_q;
    dly_d      = dly_q;
    case (state_q)
      IDLE: begin
        if (bus.init) state_d = FETCH;
      end
      FETCH: begin
        if (bus.px_ready) state_d = SHIFT;
      end
      SHIFT: begin
        if (col_q == CW'(COLS - 1)) begin
          col_d   = '0;
          state_d = LATCH;
        end else begin
          col_d   = col_q + CW'(1);
          state_d = FETCH;
        end
      end
      LATCH: begin
        disp_row_d = row_q;
        dly_d      = DW'(BASE_DLY) << plane_q;
        state_d    = SHOW;
      end
      SHOW: begin
        if (last_show) begin
          dly_d = '0;
          if (last_plane) begin
            plane_d = '0;
            row_d   = last_row ? '0 : row_q + RW'(1);
          end else begin
            plane_d = plane_q + PW'(1);
          end
          // init is only consulted here, so dropping it never truncates a plane.
          state_d = bus.init ? FETCH : IDLE;
        end else begin
          dly_d = dly_q - DW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      col_q      <= '0;
      row_q      <= '0;
      plane_q    <= '0;
      disp_row_q <= '0;
      dly_q      <= '0;
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      row_q      <= row_d;
      plane_q    <= plane_d;
      disp_row_q <= disp_row_d;
      dly_q      <= dly_d;
    end
  end

  // All strobes decode from a single state, so they are mutually exclusive by construction.
  assign bus.row        = row_q;
  assign bus.col        = col_q;
  assign bus.plane      = plane_q;
  assign bus.disp_row   = disp_row_q;
  assign bus.px_load    = (state_q == FETCH) && bus.px_ready;
  assign bus.px_clk_en  = (state_q == SHIFT);
  assign bus.latch      = (state_q == LATCH);
  assign bus.noe        = (state_q != SHOW);
  assign bus.busy       = (state_q != IDLE);
  assign bus.frame_done = last_show && last_plane && last_row;

endmodule

// File: tb/tb_led_scan_ctrl.sv
// Directed bench for led_scan_ctrl: a scoreboard of expected (row, plane, show length)
// is filled as each phase is started and drained by a monitor on every latch.
module tb_led_scan_ctrl;
  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  led_scan_ctrl_if #(.COLS(64), .ROWS(32), .PLANES(4)) bus ();

  led_scan_ctrl #(.COLS(64), .ROWS(32), .PLANES(4), .BASE_DLY(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int row;
    int plane;
    int len;
  } exp_t;

  exp_t sb_q[$];
  int   total  = 0;
  int   passed = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_plane(input int r, input int p);
    exp_t e;
    e.row   = r;
    e.plane = p;
    e.len   = 16 << p;
    sb_q.push_back(e);
  endtask

  // Monitor: strobe invariants every cycle, plus scoreboard pop on latch and SHOW length.
  exp_t cur;
  int   show_cnt = 0;
  bit   in_show  = 1'b0;

  always @(negedge clk) begin
    if (!rst) begin
      in_show  = 1'b0;
      show_cnt = 0;
    end else begin
      chk("noe_during_strobe", 32'((bus.latch || bus.px_clk_en) && !bus.noe), 32'd0);
      chk("strobe_overlap",
          32'($countones({bus.px_load, bus.px_clk_en, bus.latch, bus.frame_done}) > 1), 32'd0);
      if (bus.latch) begin
        if (sb_q.size() == 0) begin
          chk("sb_unexpected_latch", 32'd1, 32'd0);
          cur.row = -1; cur.plane = -1; cur.len = -1;
        end else begin
          cur = sb_q.pop_front();
          chk("latch_row", 32'(bus.row), 32'(cur.row));
          chk("latch_plane", 32'(bus.plane), 32'(cur.plane));
        end
        show_cnt = 0;
        in_show  = 1'b1;
      end else if (!bus.noe) begin
        if (show_cnt == 0) chk("disp_row", 32'(bus.disp_row), 32'(cur.row));
        show_cnt++;
      end else if (in_show && show_cnt > 0) begin
        chk("show_len", 32'(show_cnt), 32'(cur.len));
        in_show = 1'b0;
      end
    end
  end

  initial begin
    int n, m, pulses, prev_row, last_chg, fd_cycle, fd_count;

    rst          = 1'b0;
    bus.init     = 1'b0;
    bus.px_ready = 1'b0;
    repeat (3) tick();
    chk("rst_noe", 32'(bus.noe), 32'd1);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_strobes", 32'({bus.latch, bus.px_load, bus.px_clk_en, bus.frame_done}), 32'd0);
    chk("rst_addr", 32'({bus.row, bus.col, bus.plane, bus.disp_row}), 32'd0);

    rst = 1'b1;
    repeat (5) tick();
    chk("idle_hold_busy", 32'(bus.busy), 32'd0);
    chk("idle_hold_noe", 32'(bus.noe), 32'd1);

    // Single plane with free-flowing pixels.
    push_plane(0, 0);
    push_plane(0, 1);
    push_plane(0, 2);
    bus.init     = 1'b1;
    bus.px_ready = 1'b1;
    tick();
    chk("fetch_entry_busy", 32'(bus.busy), 32'd1);
    n = 1;
    pulses = 0;
    while (!bus.latch && n < 400) begin
      if (bus.px_clk_en) pulses++;
      tick();
      n++;
    end
    chk("latch_cycle", 32'(n), 32'd129);
    chk("shift_pulses", 32'(pulses), 32'd64);
    tick();
    m = 0;
    while (!bus.noe && m < 100) begin
      m++;
      tick();
    end
    chk("plane0_show", 32'(m), 32'd16);
    chk("plane_after_p0", 32'(bus.plane), 32'd1);
    chk("row_after_p0", 32'(bus.row), 32'd0);

    // Pixel stall at column 5 of plane 1.
    n = 0;
    while (!(bus.px_load && bus.col == 5) && n < 100) begin
      tick();
      n++;
    end
    chk("stall_reached", 32'(bus.col), 32'd5);
    bus.px_ready = 1'b0;
    #1;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      chk("stall_col", 32'(bus.col), 32'd5);
      if (bus.px_clk_en || bus.px_load) pulses++;
      tick();
    end
    chk("stall_strobes", 32'(pulses), 32'd0);
    bus.px_ready = 1'b1;
    #1;
    chk("resume_load", 32'({bus.px_load, bus.px_clk_en}), 32'b10);
    tick();
    chk("resume_shift", 32'({bus.px_load, bus.px_clk_en}), 32'b01);
    chk("resume_col_hold", 32'(bus.col), 32'd5);
    tick();
    chk("resume_col_next", 32'(bus.col), 32'd6);

    // Drop init during SHIFT of plane 2; the plane must still complete.
    n = 0;
    while (!(bus.plane == 2 && bus.px_clk_en) && n < 3000) begin
      tick();
      n++;
    end
    chk("plane2_shift_seen", 32'({bus.plane == 2, bus.px_clk_en}), 32'b11);
    bus.init = 1'b0;
    n = 0;
    while (bus.busy && n < 3000) begin
      tick();
      n++;
    end
    chk("stop_busy", 32'(bus.busy), 32'd0);
    chk("stop_noe", 32'(bus.noe), 32'd1);
    chk("stop_plane", 32'(bus.plane), 32'd3);
    chk("stop_row", 32'(bus.row), 32'd0);
    repeat (3) tick();
    chk("stop_stays_idle", 32'({bus.busy, bus.noe}), 32'b01);

    // Reset in the middle of plane 3's SHOW.
    push_plane(0, 3);
    bus.init = 1'b1;
    n = 0;
    while (bus.noe && n < 3000) begin
      tick();
      n++;
    end
    repeat (3) tick();
    chk("pre_rst_in_show", 32'(bus.noe), 32'd0);
    rst      = 1'b0;
    bus.init = 1'b0;
    #1;
    chk("mid_rst_noe", 32'(bus.noe), 32'd1);
    chk("mid_rst_busy", 32'(bus.busy), 32'd0);
    chk("mid_rst_addr", 32'({bus.row, bus.col, bus.plane, bus.disp_row}), 32'd0);
    repeat (2) tick();
    rst = 1'b1;
    repeat (2) tick();
    chk("post_rst_idle", 32'(bus.busy), 32'd0);

    // Full frame from a clean start.
    for (int r = 0; r < 32; r++)
      for (int p = 0; p < 4; p++)
        push_plane(r, p);
    bus.init = 1'b1;
    tick();
    chk("frame_start_row", 32'(bus.row), 32'd0);
    chk("frame_start_plane", 32'(bus.plane), 32'd0);
    n        = 1;
    prev_row = 0;
    last_chg = 1;
    fd_cycle = 0;
    fd_count = 0;
    while (n <= 24193) begin
      if (bus.row != prev_row) begin
        chk("row_period", 32'(n - last_chg), 32'd756);
        last_chg = n;
        prev_row = bus.row;
      end
      if (bus.frame_done) begin
        fd_count++;
        fd_cycle = n;
      end
      if (n < 24193) tick();
      n++;
    end
    chk("frame_done_cycle", 32'(fd_cycle), 32'd24192);
    chk("frame_done_count", 32'(fd_count), 32'd1);
    chk("frame_wrap_row", 32'(bus.row), 32'd0);
    chk("frame_wrap_plane", 32'(bus.plane), 32'd0);

    push_plane(0, 0);
    bus.init = 1'b0;
    n = 0;
    while (bus.busy && n < 2000) begin
      tick();
      n++;
    end
    chk("final_idle", 32'(bus.busy), 32'd0);
    chk("final_plane", 32'(bus.plane), 32'd1);
    repeat (2) tick();
    chk("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
